// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial instruction-memory boot loader:
// FSM state encoding, frame field sizes and default timing parameters.
package imem_loader_pkg;

    // Loader FSM states (7 states, 3-bit encoding)
    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CHK     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } load_state_t;

    // 50 MHz system clock at 115200 baud
    localparam int          DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_MAX_WORDS    = 1024;

    // Frame layout: big-endian length, big-endian data words, one checksum byte
    localparam int LEN_FIELD_BYTES = 2;
    localparam int WORD_BYTES      = 2;
    localparam int CHK_FIELD_BYTES = 1;

    // Assemble a big-endian 16-bit field from its two received bytes
    function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Write port of the instruction memory as seen by the boot loader.
interface imem_loader_if;
    logic [15:0] mem_data;
    logic [15:0] mem_addr;
    logic        mem_we;

    modport master (output mem_data, output mem_addr, output mem_we);
    modport slave  (input  mem_data, input  mem_addr, input  mem_we);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-bit glitch
// rejection. Emits one-cycle byte_valid or frame_err pulses per character.
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Synchronize the line, time each bit and assemble the character LSB-first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_data    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // Only a true high-to-low edge starts a character, so a
                    // line held low after a bad stop bit does not retrigger
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        // Line back high at mid start bit: glitch, drop it
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_data    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked program image over
// UART and writes it into instruction memory, holding the CPU in reset
// until a complete verified image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned MAX_WORDS    = DEFAULT_MAX_WORDS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx,
    input  logic          restart,
    imem_loader_if.master mem,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    logic [7:0]  rx_data;
    logic        byte_valid;
    logic        frame_err;

    load_state_t state;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [15:0] word_cnt;
    logic [7:0]  chk;
    logic [15:0] len_word;
    logic        receiving;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign len_word  = be_word(len_hi, rx_data);
    assign receiving = (state != ST_DONE) && (state != ST_ERROR);

    // Frame-parsing FSM with registered memory strobe and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_LEN_HI;
            len_hi       <= '0;
            data_hi      <= '0;
            word_cnt     <= '0;
            chk          <= '0;
            mem.mem_data <= '0;
            mem.mem_addr <= '0;
            mem.mem_we   <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem.mem_we <= 1'b0;
            // Address moves on the edge that ends the strobe cycle, so data
            // and address are stable for the whole write
            if (mem.mem_we) begin
                mem.mem_addr <= mem.mem_addr + 16'd1;
            end

            if (restart && !receiving) begin
                // Restart takes priority over any byte arriving this cycle
                state    <= ST_LEN_HI;
                chk      <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (receiving && frame_err) begin
                state    <= ST_ERROR;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
            end else if (receiving && byte_valid) begin
                case (state)
                    ST_LEN_HI: begin
                        len_hi <= rx_data;
                        state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        if ({16'd0, len_word} > MAX_WORDS) begin
                            state    <= ST_ERROR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end else if (len_word == 16'd0) begin
                            state <= ST_CHK;
                        end else begin
                            word_cnt     <= len_word;
                            mem.mem_addr <= '0;
                            state        <= ST_DATA_HI;
                        end
                    end
                    ST_DATA_HI: begin
                        data_hi <= rx_data;
                        chk     <= chk ^ rx_data;
                        state   <= ST_DATA_LO;
                    end
                    ST_DATA_LO: begin
                        mem.mem_data <= be_word(data_hi, rx_data);
                        mem.mem_we   <= 1'b1;
                        chk          <= chk ^ rx_data;
                        word_cnt     <= word_cnt - 16'd1;
                        state        <= (word_cnt == 16'd1) ? ST_CHK : ST_DATA_HI;
                    end
                    ST_CHK: begin
                        if (rx_data == chk) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ST_ERROR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                    default: state <= ST_ERROR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are bit-banged onto rx, expected
// memory writes go into a scoreboard queue and are matched against strobes
// captured from the memory interface.
module tb_imem_loader;

    localparam int CPB = 8;

    logic clock;
    logic reset;
    logic rx;
    logic restart;
    logic cpu_hold;
    logic done;
    logic error;

    imem_loader_if mem_if();

    imem_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .restart (restart),
        .mem     (mem_if),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [7:0]  tx_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every strobe cycle as one {addr, data} observation
    always @(negedge clock) begin
        if (mem_if.mem_we === 1'b1) begin
            obs_q.push_back({mem_if.mem_addr, mem_if.mem_data});
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clock);
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clock);
        rx = 1'b1;
        repeat (CPB) @(posedge clock);
        $display("tx byte %02h stop=%b", b, stop_bit);
    endtask

    task automatic send_queue();
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front(), 1'b1);
        end
        repeat (2 * CPB) @(posedge clock);
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        rx = 1'b1;
        restart = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (mem_if.mem_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000", mem_if.mem_data); end
        checks++; if (mem_if.mem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0000", mem_if.mem_addr); end
        checks++; if (mem_if.mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", mem_if.mem_we); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
        checks++; if ({done, error} !== 2'b00) begin failures++; $display("FAIL reset_status: done/error got %b expected 00", {done, error}); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        $display("reset released");
    endtask

    task automatic test_normal();
        logic [31:0] e, o;
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_queue();
        @(negedge clock);
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL normal_hold_before_chk: hold/done got %b%b expected 10", cpu_hold, done); end
        send_byte(8'h40, 1'b1);
        repeat (CPB) @(negedge clock);
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL normal_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL normal_write: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL normal_done: got %b expected 1", done); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL normal_hold: got %b expected 0", cpu_hold); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL normal_error: got %b expected 0", error); end
        $display("normal load: done=%b hold=%b", done, cpu_hold);
        // Bytes after DONE must be ignored
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        repeat (CPB) @(negedge clock);
        checks++; if (obs_q.size() !== 0 || done !== 1'b1) begin failures++; $display("FAIL done_ignores_bytes: writes %0d done %b expected 0 1", obs_q.size(), done); end
        obs_q.delete();
        pulse_restart();
        checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL restart_from_done: done/hold got %b%b expected 01", done, cpu_hold); end
    endtask

    task automatic test_empty();
        tx_q = '{8'h00, 8'h00, 8'h00};
        send_queue();
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL empty_wr_count: got %0d expected 0", obs_q.size()); end
        obs_q.delete();
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL empty_done: done/hold got %b%b expected 10", done, cpu_hold); end
        $display("empty image: done=%b", done);
        pulse_restart();
    endtask

    task automatic test_bad_checksum();
        logic [31:0] e, o;
        exp_q.push_back({16'd0, 16'hFF00});
        tx_q = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
        send_queue();
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL badchk_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL badchk_write: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL badchk_status: err/hold/done got %b%b%b expected 110", error, cpu_hold, done); end
        $display("bad checksum: error=%b", error);
        pulse_restart();
        checks++; if (error !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL badchk_restart: err/hold got %b%b expected 01", error, cpu_hold); end
    endtask

    task automatic test_frame_error();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b0);
        repeat (CPB) @(negedge clock);
        checks++; if (error !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL framing_status: err/hold got %b%b expected 11", error, cpu_hold); end
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (CPB) @(negedge clock);
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL framing_writes: got %0d expected 0", obs_q.size()); end
        obs_q.delete();
        $display("framing error: error=%b", error);
        pulse_restart();
    endtask

    task automatic test_oversize();
        tx_q = '{8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78};
        send_queue();
        checks++; if (error !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL oversize_status: err/done got %b%b expected 10", error, done); end
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL oversize_writes: got %0d expected 0", obs_q.size()); end
        obs_q.delete();
        $display("oversize: error=%b", error);
        pulse_restart();
        // Exactly MAX_WORDS is still accepted
        tx_q = '{8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h0F};
        for (int i = 0; i < 4; i++) exp_q.push_back({16'(i), 16'(1 << i)});
        send_queue();
        checks++; if (obs_q.size() !== 4 || done !== 1'b1) begin failures++; $display("FAIL max_words_load: writes %0d done %b expected 4 1", obs_q.size(), done); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [31:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL max_words_write: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        pulse_restart();
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] e, o;
        exp_q.push_back({16'd0, 16'h1234});
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_queue();
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if ({mem_if.mem_data, mem_if.mem_addr} !== 32'h0) begin failures++; $display("FAIL midreset_bus: got %h expected 0", {mem_if.mem_data, mem_if.mem_addr}); end
        checks++; if ({mem_if.mem_we, cpu_hold, done, error} !== 4'b0100) begin failures++; $display("FAIL midreset_ctrl: we/hold/done/err got %b expected 0100", {mem_if.mem_we, cpu_hold, done, error}); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        exp_q.push_back({16'd0, 16'hABCD});
        tx_q = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
        send_queue();
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL midreset_wr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL midreset_write: got %h expected %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL midreset_done: done/hold got %b%b expected 10", done, cpu_hold); end
        $display("reset mid-load then reload: done=%b", done);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_empty();
        test_bad_checksum();
        test_frame_error();
        test_oversize();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
